// File: rtl/tristate_bus_arbiter.sv
// rtl/tristate_bus_arbiter.sv - round-robin owner sequencer for a shared tristate bus with one-cycle turnaround
// Optional TRISTATE_BUS_KEEPER_EN: bus holds the last driven value instead of floating when nobody owns it.
module tristate_bus_arbiter #(
    parameter int N        = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*DATA_W-1:0]    din,
    output logic [N-1:0]           gnt,
    output logic [N-1:0]           oe,
    output logic [$clog2(N)-1:0]   owner,
    output logic                   busy,
    output logic [DATA_W-1:0]      bus
);

    localparam int PW   = $clog2(N);
    localparam int HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(MAX_HOLD);
    localparam logic [HC_W-1:0] HC_SAT = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [HC_W-1:0]   hc_q, hc_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic              win_found;
    logic [PW-1:0]     win_idx;
    logic              release_now;
    logic [DATA_W-1:0] drive;

    // Scan from the farthest offset down so the lowest offset from ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr_q) + k) % N]) begin
                win_found = 1'b1;
                win_idx   = PW'((int'(ptr_q) + k) % N);
            end
        end
    end

    assign release_now = !req[owner_q] || ((MAX_HOLD != 0) && (hc_q == HC_MAX));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        hc_d    = hc_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE, TURN: begin
                if (win_found) begin
                    state_d = GRANT;
                    gnt_d   = N'(1) << win_idx;
                    owner_d = win_idx;
                    hc_d    = HC_W'(1);
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    owner_d = '0;
                    hc_d    = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = TURN;
                    gnt_d   = '0;
                    owner_d = '0;
                    hc_d    = '0;
                    ptr_d   = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
                end else if (hc_q != HC_SAT) begin
                    hc_d = hc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                owner_d = '0;
                hc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            hc_q    <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            hc_q    <= hc_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign oe    = gnt_q;
    assign owner = owner_q;
    assign busy  = |gnt_q;

    // One gated buffer per source; at most one enable is ever high.
    always_comb begin
        drive = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) drive = drive | din[i*DATA_W +: DATA_W];
        end
    end

`ifdef TRISTATE_BUS_KEEPER_EN
    logic [DATA_W-1:0] keep_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            keep_q <= '0;
        end else if (busy) begin
            keep_q <= drive;
        end
    end

    assign bus = busy ? drive : keep_q;
`else
    assign bus = busy ? drive : {DATA_W{1'bz}};
`endif

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb/tb_tristate_bus_arbiter.sv - randomized bench for tristate_bus_arbiter against an ownership-level model
module tb_tristate_bus_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MH [2] = '{8, 3};

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] din;

    logic [N-1:0]  gnt_a, oe_a, gnt_b, oe_b;
    logic [1:0]    owner_a, owner_b;
    logic          busy_a, busy_b;
    logic [DW-1:0] bus_a, bus_b;

    int checks = 0;
    int errors = 0;

    int       m_own  [2];
    int       m_ptr  [2];
    int       m_held [2];
    logic [DW-1:0] m_keep [2];
    bit       model_ready = 0;

    tristate_bus_arbiter #(.N(N), .DATA_W(DW), .MAX_HOLD(8)) dut_a (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .gnt(gnt_a), .oe(oe_a), .owner(owner_a), .busy(busy_a), .bus(bus_a)
    );

    tristate_bus_arbiter #(.N(N), .DATA_W(DW), .MAX_HOLD(3)) dut_b (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .gnt(gnt_b), .oe(oe_b), .owner(owner_b), .busy(busy_b), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Ownership model: an owner keeps the bus until its request drops or its
    // hold budget is spent; with no owner, every edge is an arbitration point.
    task automatic model_step(input int d);
        if (rst) begin
            m_own[d]  = -1;
            m_ptr[d]  = 0;
            m_held[d] = 0;
            m_keep[d] = '0;
        end else if (m_own[d] >= 0) begin
            m_keep[d] = din[m_own[d]*DW +: DW];
            if (!req[m_own[d]] || (MH[d] != 0 && m_held[d] == MH[d])) begin
                m_ptr[d] = (m_own[d] + 1) % N;
                m_own[d] = -1;
            end else begin
                m_held[d]++;
            end
        end else begin
            for (int off = 0; off < N; off++) begin
                int i;
                i = (m_ptr[d] + off) % N;
                if (m_own[d] < 0 && req[i]) begin
                    m_own[d]  = i;
                    m_held[d] = 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        if (rst) model_ready = 1;
    end

    task automatic compare(input int d, input logic [N-1:0] g, input logic [N-1:0] o,
                           input logic [1:0] ow, input logic bz, input logic [DW-1:0] b);
        logic [N-1:0]  eg;
        eg = (m_own[d] >= 0) ? (N'(1) << m_own[d]) : '0;
        chk($sformatf("gnt%0d", d), 32'(g), 32'(eg));
        chk($sformatf("oe%0d", d), 32'(o), 32'(eg));
        chk($sformatf("owner%0d", d), 32'(ow), (m_own[d] >= 0) ? 32'(m_own[d]) : 32'd0);
        chk($sformatf("busy%0d", d), 32'(bz), 32'(m_own[d] >= 0));
        checks++;
        if ($countones(o) > 1) begin
            errors++;
            $display("FAIL onehot%0d: got %b expected at most one bit", d, o);
        end
        if (m_own[d] >= 0) begin
            chk($sformatf("bus%0d", d), 32'(b), 32'(din[m_own[d]*DW +: DW]));
        end else begin
`ifdef TRISTATE_BUS_KEEPER_EN
            chk($sformatf("bus_keep%0d", d), 32'(b), 32'(m_keep[d]));
`else
            checks++;
            if (!(b === {DW{1'bz}} || b === {DW{1'b0}})) begin
                errors++;
                $display("FAIL bus_z%0d: got %h expected z", d, b);
            end
`endif
        end
    endtask

    always @(negedge clk) begin
        if (model_ready) begin
            compare(0, gnt_a, oe_a, owner_a, busy_a, bus_a);
            compare(1, gnt_b, oe_b, owner_b, busy_b, bus_b);
        end
    end

    initial begin
        rst = 1'b1;
        req = '0;
        din = '0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_gnt", 32'(gnt_a), 32'h0);
        chk("reset_busy", 32'(busy_a), 32'h0);
        chk("reset_owner", 32'(owner_b), 32'h0);

        // single requester
        #1 req = 4'b0001;
        din = ($urandom() & 32'hFFFF_FF00) | 32'h0000_00A5;
        @(negedge clk);
        chk("single_gnt", 32'(gnt_a), 32'h1);
        chk("single_bus", 32'(bus_a), 32'hA5);
        #1 req = 4'b0000;
        @(negedge clk);
        chk("single_turn", 32'(gnt_a), 32'h0);
        chk("single_turn_busy", 32'(busy_a), 32'h0);
        @(negedge clk);
        chk("single_idle", 32'(gnt_a), 32'h0);

        // timeout with a persistent request (MAX_HOLD=3)
        #1 req = 4'b0010;
        din = $urandom();
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            chk($sformatf("timeout_t%0d", t), 32'(gnt_b), (t == 4) ? 32'h0 : 32'h2);
        end

        // reset aborts an active grant
        #1 req = 4'b0000;
        rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        req = 4'b0100;
        @(negedge clk);
        chk("pre_abort_gnt", 32'(gnt_a), 32'h4);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_gnt", 32'(gnt_a), 32'h0);
        chk("abort_busy", 32'(busy_a), 32'h0);
        chk("abort_owner", 32'(owner_a), 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_abort_gnt", 32'(gnt_a), 32'h4);

        // rotation with all requesting (MAX_HOLD=8), then src 3 hands over with 1001 pending
        #1 req = 4'b0000;
        rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        req = 4'b1111;
        for (int t = 1; t <= 37; t++) begin
            @(negedge clk);
            case (t)
                1:  chk("rot_src0", 32'(gnt_a), 32'h1);
                9:  chk("rot_gap", 32'(gnt_a), 32'h0);
                10: chk("rot_src1", 32'(gnt_a), 32'h2);
                19: chk("rot_src2", 32'(gnt_a), 32'h4);
                28: chk("rot_src3", 32'(gnt_a), 32'h8);
                36: chk("rot_gap3", 32'(gnt_a), 32'h0);
                37: chk("fair_src0", 32'(gnt_a), 32'h1);
                default: ;
            endcase
            #1 din = $urandom();
            if (t == 30) req = 4'b1001;
        end

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) req = N'($urandom());
            din = $urandom();
            rst = ($urandom_range(0, 199) == 0);
        end
        #1 rst = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
